// File: rtl/icb_buffer_slice.sv
`default_nettype none
// ============================================================================
// Module      : icb_buffer_slice
// Description : ICB pipeline stage. The command channel passes through a
//               2-entry skid buffer and the response channel through a
//               RSP_DEPTH FIFO. In-flight transactions are capped, and
//               responses that arrive with nothing outstanding are flagged.
// Revision    : 1.0 - initial release
// ============================================================================
module icb_buffer_slice #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 64,
    parameter int MAX_OUTSTANDING = 4,
    parameter int RSP_DEPTH       = 4,
    localparam int MASK_W         = DATA_W / 8,
    localparam int OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_icb_cmd_valid,
    output logic              s_icb_cmd_ready,
    input  logic [ADDR_W-1:0] s_icb_cmd_addr,
    input  logic              s_icb_cmd_read,
    input  logic [DATA_W-1:0] s_icb_cmd_wdata,
    input  logic [MASK_W-1:0] s_icb_cmd_wmask,
    output logic              s_icb_rsp_valid,
    input  logic              s_icb_rsp_ready,
    output logic [DATA_W-1:0] s_icb_rsp_rdata,
    output logic              s_icb_rsp_err,
    output logic              m_icb_cmd_valid,
    input  logic              m_icb_cmd_ready,
    output logic [ADDR_W-1:0] m_icb_cmd_addr,
    output logic              m_icb_cmd_read,
    output logic [DATA_W-1:0] m_icb_cmd_wdata,
    output logic [MASK_W-1:0] m_icb_cmd_wmask,
    input  logic              m_icb_rsp_valid,
    output logic              m_icb_rsp_ready,
    input  logic [DATA_W-1:0] m_icb_rsp_rdata,
    input  logic              m_icb_rsp_err,
    output logic [OUT_W-1:0]  outstanding,
    output logic              proto_err
);

    localparam int CMD_W = ADDR_W + 1 + DATA_W + MASK_W;
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam logic [OUT_W-1:0] MAX_OUT  = OUT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] RSP_FULL = CNT_W'(RSP_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_DEPTH - 1);

    // Command skid buffer: slot0 is always the head and feeds the m_ outputs.
    logic [CMD_W-1:0] r_slot0;
    logic [CMD_W-1:0] r_slot1;
    logic [1:0]       r_cmd_cnt;
    logic             r_cmd_ready;
    logic [1:0]       w_cmd_cnt_nxt;
    logic             w_cmd_push;
    logic             w_cmd_pop;
    logic             w_cmd_wr_hi;

    // Response FIFO storage, each entry is {err, rdata}.
    logic [DATA_W:0]  r_rsp_mem [RSP_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_rsp_cnt;
    logic             r_rsp_go;
    logic             w_rsp_full;
    logic             w_rsp_hs;
    logic             w_stray;
    logic             w_rsp_push;
    logic             w_rsp_pop;

    logic [OUT_W-1:0] r_outstanding;
    logic             r_proto_err;
    logic             w_out_inc;
    logic             w_out_dec;

    // ---------------------------------------------------------------- command
    assign s_icb_cmd_ready = r_cmd_ready;
    // Outstanding only rises on a handshake, so a raised valid cannot drop.
    assign m_icb_cmd_valid = (r_cmd_cnt != 2'd0) && (r_outstanding < MAX_OUT);
    assign {m_icb_cmd_addr, m_icb_cmd_read, m_icb_cmd_wdata, m_icb_cmd_wmask} = r_slot0;

    assign w_cmd_push    = s_icb_cmd_valid && r_cmd_ready;
    assign w_cmd_pop     = m_icb_cmd_valid && m_icb_cmd_ready;
    // A new entry lands behind the head only when the head stays put.
    assign w_cmd_wr_hi   = (r_cmd_cnt == 2'd1) && !w_cmd_pop;
    assign w_cmd_cnt_nxt = r_cmd_cnt + {1'b0, w_cmd_push} - {1'b0, w_cmd_pop};

    // Skid buffer shift/fill and registered "not full" ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_slot0     <= '0;
            r_slot1     <= '0;
            r_cmd_cnt   <= 2'd0;
            r_cmd_ready <= 1'b0;
        end else begin
            r_cmd_cnt   <= w_cmd_cnt_nxt;
            r_cmd_ready <= (w_cmd_cnt_nxt != 2'd2);
            if (w_cmd_pop) begin
                r_slot0 <= r_slot1;
            end
            if (w_cmd_push) begin
                if (w_cmd_wr_hi) begin
                    r_slot1 <= {s_icb_cmd_addr, s_icb_cmd_read, s_icb_cmd_wdata, s_icb_cmd_wmask};
                end else begin
                    r_slot0 <= {s_icb_cmd_addr, s_icb_cmd_read, s_icb_cmd_wdata, s_icb_cmd_wmask};
                end
            end
        end
    end

    // --------------------------------------------------------------- response
    assign w_rsp_full      = (r_rsp_cnt == RSP_FULL);
    assign s_icb_rsp_valid = (r_rsp_cnt != '0);
    assign {s_icb_rsp_err, s_icb_rsp_rdata} = r_rsp_mem[r_rd_ptr];

    assign w_rsp_pop       = s_icb_rsp_valid && s_icb_rsp_ready;
    // A pop on the s_ side frees a slot for a push in the same cycle.
    assign m_icb_rsp_ready = r_rsp_go && (!w_rsp_full || w_rsp_pop);
    assign w_rsp_hs        = m_icb_rsp_valid && m_icb_rsp_ready;
    assign w_stray         = w_rsp_hs && (r_outstanding == '0) && !w_cmd_pop;
    assign w_rsp_push      = w_rsp_hs && !w_stray;

    // Response FIFO pointers, occupancy and storage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_rsp_cnt <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                r_rsp_mem[i] <= '0;
            end
        end else begin
            if (w_rsp_push) begin
                r_rsp_mem[r_wr_ptr] <= {m_icb_rsp_err, m_icb_rsp_rdata};
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_rsp_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            r_rsp_cnt <= r_rsp_cnt + CNT_W'(w_rsp_push) - CNT_W'(w_rsp_pop);
        end
    end

    // ------------------------------------------------------------ bookkeeping
    assign w_out_inc   = w_cmd_pop;
    assign w_out_dec   = w_rsp_pop && (r_outstanding != '0);
    assign outstanding = r_outstanding;
    assign proto_err   = r_proto_err;

    // In-flight counter, sticky stray-response flag and post-reset enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_outstanding <= '0;
            r_proto_err   <= 1'b0;
            r_rsp_go      <= 1'b0;
        end else begin
            r_rsp_go <= 1'b1;
            if (w_out_inc && !w_out_dec) begin
                r_outstanding <= r_outstanding + 1'b1;
            end else if (!w_out_inc && w_out_dec) begin
                r_outstanding <= r_outstanding - 1'b1;
            end
            if (w_stray) begin
                r_proto_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icb_buffer_slice.sv
`default_nettype none
// ============================================================================
// Module      : tb_icb_buffer_slice
// Description : Directed self-checking bench for icb_buffer_slice.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icb_buffer_slice;

    logic        clk;
    logic        rst_n;
    logic        s_icb_cmd_valid;
    logic        s_icb_cmd_ready;
    logic [31:0] s_icb_cmd_addr;
    logic        s_icb_cmd_read;
    logic [63:0] s_icb_cmd_wdata;
    logic [7:0]  s_icb_cmd_wmask;
    logic        s_icb_rsp_valid;
    logic        s_icb_rsp_ready;
    logic [63:0] s_icb_rsp_rdata;
    logic        s_icb_rsp_err;
    logic        m_icb_cmd_valid;
    logic        m_icb_cmd_ready;
    logic [31:0] m_icb_cmd_addr;
    logic        m_icb_cmd_read;
    logic [63:0] m_icb_cmd_wdata;
    logic [7:0]  m_icb_cmd_wmask;
    logic        m_icb_rsp_valid;
    logic        m_icb_rsp_ready;
    logic [63:0] m_icb_rsp_rdata;
    logic        m_icb_rsp_err;
    logic [2:0]  outstanding;
    logic        proto_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Handshake logs filled by the monitor below.
    int          m_hs_cnt = 0;
    int          rsp_cnt  = 0;
    logic [31:0] cmd_addr_log [64];
    logic [64:0] rsp_log      [64];

    icb_buffer_slice #(
        .ADDR_W(32), .DATA_W(64), .MAX_OUTSTANDING(4), .RSP_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_icb_cmd_valid(s_icb_cmd_valid), .s_icb_cmd_ready(s_icb_cmd_ready),
        .s_icb_cmd_addr(s_icb_cmd_addr), .s_icb_cmd_read(s_icb_cmd_read),
        .s_icb_cmd_wdata(s_icb_cmd_wdata), .s_icb_cmd_wmask(s_icb_cmd_wmask),
        .s_icb_rsp_valid(s_icb_rsp_valid), .s_icb_rsp_ready(s_icb_rsp_ready),
        .s_icb_rsp_rdata(s_icb_rsp_rdata), .s_icb_rsp_err(s_icb_rsp_err),
        .m_icb_cmd_valid(m_icb_cmd_valid), .m_icb_cmd_ready(m_icb_cmd_ready),
        .m_icb_cmd_addr(m_icb_cmd_addr), .m_icb_cmd_read(m_icb_cmd_read),
        .m_icb_cmd_wdata(m_icb_cmd_wdata), .m_icb_cmd_wmask(m_icb_cmd_wmask),
        .m_icb_rsp_valid(m_icb_rsp_valid), .m_icb_rsp_ready(m_icb_rsp_ready),
        .m_icb_rsp_rdata(m_icb_rsp_rdata), .m_icb_rsp_err(m_icb_rsp_err),
        .outstanding(outstanding), .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every handshake on the m_ command and s_ response sides.
    always @(posedge clk) begin
        if (m_icb_cmd_valid && m_icb_cmd_ready) begin
            cmd_addr_log[m_hs_cnt % 64] = m_icb_cmd_addr;
            m_hs_cnt = m_hs_cnt + 1;
        end
        if (s_icb_rsp_valid && s_icb_rsp_ready) begin
            rsp_log[rsp_cnt % 64] = {s_icb_rsp_err, s_icb_rsp_rdata};
            rsp_cnt = rsp_cnt + 1;
        end
    end

    // Hard stop in case something never returns.
    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [31:0] a, input logic rd,
                            input logic [63:0] wd, input logic [7:0] wm);
        int t;
        s_icb_cmd_valid = 1'b1;
        s_icb_cmd_addr  = a;
        s_icb_cmd_read  = rd;
        s_icb_cmd_wdata = wd;
        s_icb_cmd_wmask = wm;
        t = 0;
        while (s_icb_cmd_ready !== 1'b1 && t < 20) begin
            tick();
            t++;
        end
        n_checks++;
        if (t >= 20) $display("FAIL send_cmd_timeout addr=%h ready got %b exp 1", a, s_icb_cmd_ready);
        else n_pass++;
        tick();
        s_icb_cmd_valid = 1'b0;
    endtask

    // Single write with a slave that responds one cycle after the command.
    task automatic run_write(input logic [31:0] a, input logic [63:0] wd, input logic [7:0] wm);
        m_icb_cmd_ready = 1'b1;
        s_icb_rsp_ready = 1'b1;
        s_icb_cmd_valid = 1'b1;
        s_icb_cmd_addr  = a;
        s_icb_cmd_read  = 1'b0;
        s_icb_cmd_wdata = wd;
        s_icb_cmd_wmask = wm;
        n_checks++; if (s_icb_cmd_ready !== 1'b1) $display("FAIL wr_s_ready got %b exp 1", s_icb_cmd_ready); else n_pass++;
        n_checks++; if (outstanding !== 3'd0) $display("FAIL wr_out0 got %0d exp 0", outstanding); else n_pass++;
        tick();
        s_icb_cmd_valid = 1'b0;
        n_checks++; if (m_icb_cmd_valid !== 1'b1) $display("FAIL wr_m_valid got %b exp 1", m_icb_cmd_valid); else n_pass++;
        n_checks++;
        if ({m_icb_cmd_addr, m_icb_cmd_read, m_icb_cmd_wdata, m_icb_cmd_wmask} !== {a, 1'b0, wd, wm})
            $display("FAIL wr_m_payload got %h/%b/%h/%h exp %h/0/%h/%h",
                     m_icb_cmd_addr, m_icb_cmd_read, m_icb_cmd_wdata, m_icb_cmd_wmask, a, wd, wm);
        else n_pass++;
        n_checks++; if (outstanding !== 3'd0) $display("FAIL wr_out_pre got %0d exp 0", outstanding); else n_pass++;
        tick();
        n_checks++; if (m_icb_cmd_valid !== 1'b0) $display("FAIL wr_m_valid_drop got %b exp 0", m_icb_cmd_valid); else n_pass++;
        n_checks++; if (outstanding !== 3'd1) $display("FAIL wr_out1 got %0d exp 1", outstanding); else n_pass++;
        m_icb_rsp_valid = 1'b1;
        m_icb_rsp_rdata = 64'h0;
        m_icb_rsp_err   = 1'b0;
        n_checks++; if (m_icb_rsp_ready !== 1'b1) $display("FAIL wr_m_rsp_ready got %b exp 1", m_icb_rsp_ready); else n_pass++;
        n_checks++; if (s_icb_rsp_valid !== 1'b0) $display("FAIL wr_s_rsp_early got %b exp 0", s_icb_rsp_valid); else n_pass++;
        tick();
        m_icb_rsp_valid = 1'b0;
        n_checks++; if (s_icb_rsp_valid !== 1'b1) $display("FAIL wr_s_rsp_valid got %b exp 1", s_icb_rsp_valid); else n_pass++;
        n_checks++; if (s_icb_rsp_err !== 1'b0) $display("FAIL wr_s_rsp_err got %b exp 0", s_icb_rsp_err); else n_pass++;
        n_checks++; if (outstanding !== 3'd1) $display("FAIL wr_out_hold got %0d exp 1", outstanding); else n_pass++;
        tick();
        n_checks++; if (s_icb_rsp_valid !== 1'b0) $display("FAIL wr_s_rsp_done got %b exp 0", s_icb_rsp_valid); else n_pass++;
        n_checks++; if (outstanding !== 3'd0) $display("FAIL wr_out_end got %0d exp 0", outstanding); else n_pass++;
        s_icb_rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_icb_cmd_valid = 1'b0; s_icb_cmd_addr = '0; s_icb_cmd_read = 1'b0;
        s_icb_cmd_wdata = '0; s_icb_cmd_wmask = '0; s_icb_rsp_ready = 1'b0;
        m_icb_cmd_ready = 1'b0; m_icb_rsp_valid = 1'b0; m_icb_rsp_rdata = '0; m_icb_rsp_err = 1'b0;
        repeat (3) tick();
        n_checks++; if (s_icb_cmd_ready !== 1'b0) $display("FAIL rst_s_cmd_ready got %b exp 0", s_icb_cmd_ready); else n_pass++;
        n_checks++; if (m_icb_rsp_ready !== 1'b0) $display("FAIL rst_m_rsp_ready got %b exp 0", m_icb_rsp_ready); else n_pass++;
        n_checks++; if (m_icb_cmd_valid !== 1'b0) $display("FAIL rst_m_cmd_valid got %b exp 0", m_icb_cmd_valid); else n_pass++;
        n_checks++; if (s_icb_rsp_valid !== 1'b0) $display("FAIL rst_s_rsp_valid got %b exp 0", s_icb_rsp_valid); else n_pass++;
        n_checks++;
        if ({m_icb_cmd_addr, m_icb_cmd_read, m_icb_cmd_wdata, m_icb_cmd_wmask, s_icb_rsp_rdata, s_icb_rsp_err} !== '0)
            $display("FAIL rst_data got %h/%h/%h/%h exp 0", m_icb_cmd_addr, m_icb_cmd_wdata, m_icb_cmd_wmask, s_icb_rsp_rdata);
        else n_pass++;
        n_checks++; if (outstanding !== 3'd0) $display("FAIL rst_outstanding got %0d exp 0", outstanding); else n_pass++;
        n_checks++; if (proto_err !== 1'b0) $display("FAIL rst_proto_err got %b exp 0", proto_err); else n_pass++;
        rst_n = 1'b1;
        tick();
        n_checks++; if (s_icb_cmd_ready !== 1'b1) $display("FAIL rel_s_cmd_ready got %b exp 1", s_icb_cmd_ready); else n_pass++;
        n_checks++; if (m_icb_rsp_ready !== 1'b1) $display("FAIL rel_m_rsp_ready got %b exp 1", m_icb_rsp_ready); else n_pass++;
    endtask

    task automatic test_single_write();
        run_write(32'h0000_1000, 64'h1122_3344_5566_7788, 8'hFF);
    endtask

    // Six reads against a stalled responder, then drain four in order.
    task automatic test_back_to_back();
        int          base_m;
        int          base_r;
        logic [64:0] exp_rsp;
        base_m = m_hs_cnt;
        base_r = rsp_cnt;
        m_icb_cmd_ready = 1'b1;
        s_icb_rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send_cmd(32'h2000 + 32'(i * 4), 1'b1, 64'h0, 8'h00);
        end
        repeat (4) tick();
        n_checks++; if (m_hs_cnt - base_m !== 4) $display("FAIL b2b_m_hs got %0d exp 4", m_hs_cnt - base_m); else n_pass++;
        n_checks++; if (m_icb_cmd_valid !== 1'b0) $display("FAIL b2b_m_valid_cap got %b exp 0", m_icb_cmd_valid); else n_pass++;
        n_checks++; if (outstanding !== 3'd4) $display("FAIL b2b_outstanding got %0d exp 4", outstanding); else n_pass++;
        n_checks++; if (s_icb_cmd_ready !== 1'b0) $display("FAIL b2b_s_ready_full got %b exp 0", s_icb_cmd_ready); else n_pass++;
        n_checks++; if (cmd_addr_log[(base_m + 3) % 64] !== 32'h200C) $display("FAIL b2b_order got %h exp 0000200c", cmd_addr_log[(base_m + 3) % 64]); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            m_icb_rsp_valid = 1'b1;
            m_icb_rsp_err   = 1'b0;
            m_icb_rsp_rdata = 64'hA0 + 64'(k);
            n_checks++; if (m_icb_rsp_ready !== 1'b1) $display("FAIL b2b_fill_ready k=%0d got %b exp 1", k, m_icb_rsp_ready); else n_pass++;
            tick();
        end
        m_icb_rsp_valid = 1'b0;
        n_checks++; if (m_icb_rsp_ready !== 1'b0) $display("FAIL b2b_rsp_full got %b exp 0", m_icb_rsp_ready); else n_pass++;
        n_checks++; if (s_icb_rsp_valid !== 1'b1) $display("FAIL b2b_rsp_valid got %b exp 1", s_icb_rsp_valid); else n_pass++;
        n_checks++; if (s_icb_rsp_rdata !== 64'hA0) $display("FAIL b2b_rsp_head got %h exp a0", s_icb_rsp_rdata); else n_pass++;
        s_icb_rsp_ready = 1'b1;
        repeat (10) tick();
        for (int k = 0; k < 4; k++) begin
            exp_rsp = {1'b0, 64'hA0 + 64'(k)};
            n_checks++;
            if (rsp_log[(base_r + k) % 64] !== exp_rsp) $display("FAIL b2b_drain k=%0d got %h exp %h", k, rsp_log[(base_r + k) % 64], exp_rsp);
            else n_pass++;
        end
        n_checks++; if (m_hs_cnt - base_m !== 6) $display("FAIL b2b_rest_issued got %0d exp 6", m_hs_cnt - base_m); else n_pass++;
        n_checks++; if (outstanding !== 3'd2) $display("FAIL b2b_out_after got %0d exp 2", outstanding); else n_pass++;
        n_checks++; if (s_icb_cmd_ready !== 1'b1) $display("FAIL b2b_s_ready_back got %b exp 1", s_icb_cmd_ready); else n_pass++;
        // Retire the last two reads.
        m_icb_rsp_valid = 1'b1; m_icb_rsp_rdata = 64'hB0; tick();
        m_icb_rsp_rdata = 64'hB1; tick();
        m_icb_rsp_valid = 1'b0;
        repeat (3) tick();
        n_checks++; if (rsp_log[(base_r + 5) % 64] !== {1'b0, 64'hB1}) $display("FAIL b2b_tail got %h exp b1", rsp_log[(base_r + 5) % 64]); else n_pass++;
        n_checks++; if (outstanding !== 3'd0) $display("FAIL b2b_out_zero got %0d exp 0", outstanding); else n_pass++;
        s_icb_rsp_ready = 1'b0;
    endtask

    task automatic test_err_response();
        m_icb_cmd_ready = 1'b1;
        s_icb_rsp_ready = 1'b0;
        send_cmd(32'h3000, 1'b1, 64'h0, 8'h00);
        tick();
        n_checks++; if (outstanding !== 3'd1) $display("FAIL err_out1 got %0d exp 1", outstanding); else n_pass++;
        m_icb_rsp_valid = 1'b1;
        m_icb_rsp_err   = 1'b1;
        m_icb_rsp_rdata = 64'hDEAD;
        tick();
        m_icb_rsp_valid = 1'b0;
        m_icb_rsp_err   = 1'b0;
        n_checks++; if (s_icb_rsp_valid !== 1'b1) $display("FAIL err_valid got %b exp 1", s_icb_rsp_valid); else n_pass++;
        n_checks++; if (s_icb_rsp_err !== 1'b1) $display("FAIL err_flag got %b exp 1", s_icb_rsp_err); else n_pass++;
        n_checks++; if (s_icb_rsp_rdata !== 64'hDEAD) $display("FAIL err_rdata got %h exp dead", s_icb_rsp_rdata); else n_pass++;
        s_icb_rsp_ready = 1'b1;
        tick();
        s_icb_rsp_ready = 1'b0;
        n_checks++; if (outstanding !== 3'd0) $display("FAIL err_out_dec got %0d exp 0", outstanding); else n_pass++;
        n_checks++; if (s_icb_rsp_valid !== 1'b0) $display("FAIL err_popped got %b exp 0", s_icb_rsp_valid); else n_pass++;
    endtask

    task automatic test_reset_midflight();
        int base_m;
        m_icb_cmd_ready = 1'b1;
        s_icb_rsp_ready = 1'b0;
        send_cmd(32'h4000, 1'b1, 64'h0, 8'h00);
        send_cmd(32'h4004, 1'b1, 64'h0, 8'h00);
        tick();
        m_icb_cmd_ready = 1'b0;
        send_cmd(32'h4008, 1'b0, 64'hCAFE, 8'h0F);
        n_checks++; if (outstanding !== 3'd2) $display("FAIL mid_out2 got %0d exp 2", outstanding); else n_pass++;
        n_checks++; if (m_icb_cmd_valid !== 1'b1) $display("FAIL mid_held got %b exp 1", m_icb_cmd_valid); else n_pass++;
        rst_n = 1'b0;
        tick();
        n_checks++; if (outstanding !== 3'd0) $display("FAIL mid_rst_out got %0d exp 0", outstanding); else n_pass++;
        n_checks++; if (m_icb_cmd_valid !== 1'b0) $display("FAIL mid_rst_m_valid got %b exp 0", m_icb_cmd_valid); else n_pass++;
        n_checks++; if (s_icb_cmd_ready !== 1'b0) $display("FAIL mid_rst_s_ready got %b exp 0", s_icb_cmd_ready); else n_pass++;
        n_checks++; if (m_icb_rsp_ready !== 1'b0) $display("FAIL mid_rst_rsp_ready got %b exp 0", m_icb_rsp_ready); else n_pass++;
        n_checks++;
        if ({m_icb_cmd_addr, m_icb_cmd_wdata, m_icb_cmd_wmask, m_icb_cmd_read} !== '0)
            $display("FAIL mid_rst_payload got %h/%h/%h exp 0", m_icb_cmd_addr, m_icb_cmd_wdata, m_icb_cmd_wmask);
        else n_pass++;
        rst_n = 1'b1;
        tick();
        n_checks++; if (s_icb_cmd_ready !== 1'b1) $display("FAIL mid_rel_ready got %b exp 1", s_icb_cmd_ready); else n_pass++;
        n_checks++; if (m_icb_cmd_valid !== 1'b0) $display("FAIL mid_no_replay got %b exp 0", m_icb_cmd_valid); else n_pass++;
        base_m = m_hs_cnt;
        run_write(32'h5000, 64'h0123_4567_89AB_CDEF, 8'h3C);
        n_checks++; if (m_hs_cnt - base_m !== 1) $display("FAIL mid_fresh_count got %0d exp 1", m_hs_cnt - base_m); else n_pass++;
        n_checks++; if (cmd_addr_log[base_m % 64] !== 32'h5000) $display("FAIL mid_fresh_addr got %h exp 00005000", cmd_addr_log[base_m % 64]); else n_pass++;
    endtask

    task automatic test_proto_err();
        rst_n = 1'b0;
        m_icb_cmd_ready = 1'b0;
        s_icb_rsp_ready = 1'b1;
        m_icb_rsp_valid = 1'b1;
        m_icb_rsp_rdata = 64'h55;
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if (m_icb_rsp_ready !== 1'b1) $display("FAIL pe_ready got %b exp 1", m_icb_rsp_ready); else n_pass++;
        n_checks++; if (proto_err !== 1'b0) $display("FAIL pe_early got %b exp 0", proto_err); else n_pass++;
        tick();
        m_icb_rsp_valid = 1'b0;
        n_checks++; if (proto_err !== 1'b1) $display("FAIL pe_set got %b exp 1", proto_err); else n_pass++;
        n_checks++; if (s_icb_rsp_valid !== 1'b0) $display("FAIL pe_discard got %b exp 0", s_icb_rsp_valid); else n_pass++;
        n_checks++; if (outstanding !== 3'd0) $display("FAIL pe_out got %0d exp 0", outstanding); else n_pass++;
        repeat (2) tick();
        n_checks++; if (proto_err !== 1'b1) $display("FAIL pe_sticky got %b exp 1", proto_err); else n_pass++;
        n_checks++; if (s_icb_rsp_valid !== 1'b0) $display("FAIL pe_still_empty got %b exp 0", s_icb_rsp_valid); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_err_response();
        test_reset_midflight();
        test_proto_err();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/icb_buffer_slice.md
Name: icb_buffer_slice

Overview:
Parametrised ICB pipeline/buffer stage between an ICB master (s_ side) and an ICB slave (m_ side), for example between the core and the ICB-to-APB bridge.
- Registers the command channel through a 2-entry skid buffer.
- Buffers responses in a RSP_DEPTH FIFO.
- Caps in-flight transactions at MAX_OUTSTANDING.
- Flags responses that arrive with nothing outstanding.

Parameters:
ADDR_W, 32, command address width
DATA_W, 64, write/read data width; multiple of 8; mask width MASK_W = DATA_W/8
MAX_OUTSTANDING, 4, max commands accepted on m_ side whose responses are not yet accepted on s_ side; >=1
RSP_DEPTH, 4, response FIFO depth; power of two, >= MAX_OUTSTANDING

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low
s_icb_cmd_valid  in  1  upstream command valid
s_icb_cmd_ready  out  1  upstream command ready
s_icb_cmd_addr  in  ADDR_W  command address
s_icb_cmd_read  in  1  1=read, 0=write
s_icb_cmd_wdata  in  DATA_W  write data
s_icb_cmd_wmask  in  MASK_W  write byte mask
s_icb_rsp_valid  out  1  upstream response valid
s_icb_rsp_ready  in  1  upstream response ready
s_icb_rsp_rdata  out  DATA_W  read data
s_icb_rsp_err  out  1  response error
m_icb_cmd_valid  out  1  downstream command valid
m_icb_cmd_ready  in  1  downstream command ready
m_icb_cmd_addr  out  ADDR_W  command address
m_icb_cmd_read  out  1  read flag
m_icb_cmd_wdata  out  DATA_W  write data
m_icb_cmd_wmask  out  MASK_W  write mask
m_icb_rsp_valid  in  1  downstream response valid
m_icb_rsp_ready  out  1  downstream response ready
m_icb_rsp_rdata  in  DATA_W  read data
m_icb_rsp_err  in  1  response error
outstanding  out  $clog2(MAX_OUTSTANDING+1)  in-flight transaction count
proto_err  out  1  sticky: response seen with outstanding==0

Behaviour:
- Reset and handshakes:
  - Reset: synchronous on clk while rst_n==0.
  - All valids 0, s_icb_cmd_ready 0, m_icb_rsp_ready 0, all data/addr/mask outputs 0, outstanding 0, proto_err 0.
  - Both FIFOs are emptied. In-flight transactions are dropped, with no replay.
  - The ready outputs go to 1 on the first cycle after rst_n rises.
  - A handshake is valid&&ready at a posedge. Valid, once asserted, holds with stable payload until its handshake completes, on both output sides.
- Command path (2-entry skid buffer):
  - All m_icb_cmd_* outputs are driven from registers.
  - A command accepted at edge N appears on m_icb_cmd_valid after edge N, i.e. 1-cycle latency.
  - s_icb_cmd_ready is registered and equals "skid not full". Full throughput is 1 command/cycle when downstream is ready.
  - Order is preserved.
- Outstanding limit:
  - m_icb_cmd_valid is asserted only when the buffer is non-empty and outstanding < MAX_OUTSTANDING.
  - A held command (valid already 1) is never withdrawn.
  - outstanding +1 on an m_ command handshake and -1 on an s_ response handshake. When both occur in the same cycle it is unchanged.
  - outstanding never exceeds MAX_OUTSTANDING and never goes below 0.
- Response path (FIFO, RSP_DEPTH entries):
  - An entry is {err, rdata}. m_icb_rsp_ready = FIFO not full.
  - A response written at edge N is visible on s_icb_rsp_* after edge N.
  - s_icb_rsp_valid = FIFO not empty. Output data comes from the head entry.
  - Simultaneous push and pop is allowed when full or empty: pop frees a slot in the same cycle, and push/pop in the same cycle keeps the count.
  - Pointers wrap modulo RSP_DEPTH.
- proto_err:
  - Set when m_icb_rsp_valid&&m_icb_rsp_ready while outstanding==0 and no m_ command handshake occurs in the same cycle.
  - The offending response is discarded, not pushed. Cleared only by reset.
- Error pass-through: m_icb_rsp_err propagates unchanged, and an err response still decrements outstanding on its s_ handshake.

Test Plan:
- Single write addr=0x1000, wdata=0x1122334455667788, wmask=0xFF; slave ready and responds the next cycle -> m_ cmd matches bit-exact one cycle after the s_ handshake; s_icb_rsp_valid one cycle after the m_ response; outstanding sequence 0,1,0.
- 6 back-to-back reads, m_icb_cmd_ready=1, slave withholds responses -> exactly 4 m_ handshakes, then m_icb_cmd_valid stays 0 with outstanding=4. s_icb_cmd_ready drops after 2 further commands are buffered.
- Continuing from the previous scenario, slave returns 4 responses with rdata 0xA0..0xA3 and s_icb_rsp_ready=0 -> FIFO full, m_icb_rsp_ready=0. Then s_icb_rsp_ready=1 -> rdata delivered in order A0..A3 and the remaining 2 commands issue.
- m_icb_rsp_valid=1 at reset release with nothing sent -> proto_err=1 next cycle, s_icb_rsp_valid stays 0, outstanding stays 0.
- Response with m_icb_rsp_err=1, rdata=0xDEAD -> s_icb_rsp_err=1, rdata=0xDEAD, outstanding decrements.
- rst_n=0 for one cycle with 2 outstanding and 1 command buffered -> all outputs at reset values the next cycle, outstanding=0; a fresh write afterwards completes normally.
